// File: rtl/mips_control_fsm_if.sv
// Control bus between the multi-cycle MIPS control unit and its datapath.
// The master modport is the control unit; the slave modport is the datapath side.
interface mips_control_fsm_if #(
  parameter int RETIRE_W = 16
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                Zero;
  logic                mem_ready;

  logic [2:0]          ALUOp;
  logic                PCSrc;
  logic                RegDst;
  logic                ALUSrc;
  logic                MemToReg;
  logic                regWrite;
  logic                MemWrite;
  logic                MemRead;
  logic                IRWrite;
  logic                PCWrite;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired;
  logic                illegal;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output ALUOp, PCSrc, RegDst, ALUSrc, MemToReg,
           regWrite, MemWrite, MemRead, IRWrite, PCWrite,
           state, retired, illegal
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  ALUOp, PCSrc, RegDst, ALUSrc, MemToReg,
           regWrite, MemWrite, MemRead, IRWrite, PCWrite,
           state, retired, illegal
  );
endinterface

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with retire counter.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes into an absorbing HALT state.
module mips_control_fsm #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  mips_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_e              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic       is_r, is_addi, is_lw, is_sw, is_beq;
  logic       r_valid;
  logic [2:0] r_aluop;
  logic       pc_write;

  // Instruction class comes from the latched opcode so later opcode changes are ignored.
  assign is_r    = (opcode_q == OP_RTYPE);
  assign is_addi = (opcode_q == OP_ADDI);
  assign is_lw   = (opcode_q == OP_LW);
  assign is_sw   = (opcode_q == OP_SW);
  assign is_beq  = (opcode_q == OP_BEQ);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    r_valid = 1'b1;
    r_aluop = ALU_ADD;
    case (funct_q)
      FN_ADD:  r_aluop = ALU_ADD;
      FN_SUB:  r_aluop = ALU_SUB;
      FN_AND:  r_aluop = ALU_AND;
      FN_OR:   r_aluop = ALU_OR;
      FN_SLT:  r_aluop = ALU_SLT;
      default: r_valid = 1'b0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic op_supported;

  assign op_supported = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_ADDI) ||
                        (bus.opcode == OP_LW)    || (bus.opcode == OP_SW)   ||
                        (bus.opcode == OP_BEQ);
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        opcode_d = bus.opcode;
        funct_d  = bus.funct;
        state_d  = EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (!op_supported) state_d = HALT;
`endif
      end
      EXEC: begin
        if (is_r || is_addi)    state_d = WB;
        else if (is_lw || is_sw) state_d = MEM;
        else                     state_d = FETCH;
      end
      MEM: begin
        if (bus.mem_ready) state_d = is_lw ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so nothing strobes during reset.
  always_comb begin
    bus.ALUOp    = ALU_ADD;
    bus.PCSrc    = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.regWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.IRWrite  = 1'b0;
    pc_write     = 1'b0;
    if (!reset) begin
      bus.IRWrite = (state_q == FETCH);
      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
        bus.RegDst   = is_r;
        bus.ALUSrc   = is_addi || is_lw || is_sw;
        bus.MemToReg = is_lw;
        if (is_r)        bus.ALUOp = r_aluop;
        else if (is_beq) bus.ALUOp = ALU_SUB;
      end
      case (state_q)
        EXEC: begin
          if (is_beq) bus.PCSrc = bus.Zero;
          pc_write = !(is_r || is_addi || is_lw || is_sw);
        end
        MEM: begin
          bus.MemRead  = is_lw;
          bus.MemWrite = is_sw;
          // A stalled sw must not retire, so its PC update waits for the ready cycle.
          pc_write     = is_sw && bus.mem_ready;
        end
        WB: begin
          bus.regWrite = is_addi || is_lw || (is_r && r_valid);
          pc_write     = 1'b1;
        end
        default: ;
      endcase
    end
    bus.PCWrite = pc_write;
  end

  assign retired_d = pc_write ? retired_q + RETIRE_W'(1) : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_d = illegal_q || (state_q == DECODE && !op_supported);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule
